// File: rtl/iob_ram_pkg.sv
// Shared RAM definitions: write-mode encodings and column-count helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package iob_ram_pkg;

   // Write-mode encodings selected by the WR_MODE parameter
   localparam int WR_RF = 0;   // read-first: q shows the pre-write word
   localparam int WR_WF = 1;   // write-first: q shows the post-write word
   localparam int WR_NC = 2;   // no-change: writes leave q untouched

   // Number of write-enable columns in a word
   function automatic int ncol(input int data_w, input int col_w);
      return data_w / col_w;
   endfunction

endpackage

// File: rtl/iob_ram_port_out.sv
// Per-port read-out path: mode select, optional output register, rvalid pipeline.
// Latency: 1 cycle from access to q/rvalid, 2 cycles with OUT_REG=1.
// Backpressure: none; every qualifying access produces exactly one rvalid pulse.
module iob_ram_port_out
   import iob_ram_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int WR_MODE = 0,
   parameter int OUT_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              wr,
   input  logic [DATA_W-1:0] d_old,
   input  logic [DATA_W-1:0] d_new,
   output logic [DATA_W-1:0] q,
   output logic              rvalid
);

   logic [DATA_W-1:0] q1;
   logic              v1;
   logic [DATA_W-1:0] q_pipe;
   logic              v_pipe;
   logic              take;

   // No-change mode only returns data for pure reads
   assign take = en && ((WR_MODE != WR_NC) || !wr);

   // First stage: capture the mode-selected word for every accepted access
   always_ff @(posedge clk) begin
      if (rst) begin
         q1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= take;
         if (take) begin
            q1 <= (WR_MODE == WR_WF) ? d_new : d_old;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] q2;
         logic              v2;

         // Optional second stage: moves data only alongside a valid
         always_ff @(posedge clk) begin
            if (rst) begin
               q2 <= '0;
               v2 <= 1'b0;
            end else begin
               v2 <= v1;
               if (v1) begin
                  q2 <= q1;
               end
            end
         end

         assign q_pipe = q2;
         assign v_pipe = v2;
      end else begin : g_noreg
         assign q_pipe = q1;
         assign v_pipe = v1;
      end
   endgenerate

   // Reset also squashes the result landing in the reset cycle itself
   assign q      = rst ? '0 : q_pipe;
   assign rvalid = v_pipe & ~rst;

endmodule

// File: rtl/iob_tdp_ram_be_cfg.sv
// True dual-port RAM with per-column write enables, configurable write mode and output register.
// Latency: read data and rvalid 1 + OUT_REG cycles after the enabled access.
// Backpressure: none; both ports accept an access every cycle, port A wins column conflicts.
module iob_tdp_ram_be_cfg
   import iob_ram_pkg::*;
#(
   parameter     HEXFILE = "none",
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int COL_W   = 8,
   parameter int WR_MODE = 0,
   parameter int OUT_REG = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en_a,
   input  logic                             en_b,
   input  logic [ncol(DATA_W, COL_W)-1:0]   we_a,
   input  logic [ncol(DATA_W, COL_W)-1:0]   we_b,
   input  logic [ADDR_W-1:0]                addr_a,
   input  logic [ADDR_W-1:0]                addr_b,
   input  logic [DATA_W-1:0]                d_a,
   input  logic [DATA_W-1:0]                d_b,
   output logic [DATA_W-1:0]                q_a,
   output logic [DATA_W-1:0]                q_b,
   output logic                             rvalid_a,
   output logic                             rvalid_b,
   output logic                             coll
);

   localparam int NCOL  = ncol(DATA_W, COL_W);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic [DATA_W-1:0] old_a;
   logic [DATA_W-1:0] old_b;
   logic [DATA_W-1:0] new_a;
   logic [DATA_W-1:0] new_b;

   // Column writes; port A is applied last so it wins shared columns
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NCOL; i++) begin
            if (en_b && we_b[i]) begin
               mem[addr_b][i*COL_W +: COL_W] <= d_b[i*COL_W +: COL_W];
            end
            if (en_a && we_a[i]) begin
               mem[addr_a][i*COL_W +: COL_W] <= d_a[i*COL_W +: COL_W];
            end
         end
      end
   end

   // Pre-write words and the merged post-write words seen by each port
   always_comb begin
      old_a = mem[addr_a];
      old_b = mem[addr_b];
      new_a = old_a;
      new_b = old_b;
      for (int i = 0; i < NCOL; i++) begin
         if (en_b && we_b[i] && (addr_b == addr_a)) begin
            new_a[i*COL_W +: COL_W] = d_b[i*COL_W +: COL_W];
         end
         if (en_a && we_a[i]) begin
            new_a[i*COL_W +: COL_W] = d_a[i*COL_W +: COL_W];
         end
         if (en_b && we_b[i]) begin
            new_b[i*COL_W +: COL_W] = d_b[i*COL_W +: COL_W];
         end
         if (en_a && we_a[i] && (addr_a == addr_b)) begin
            new_b[i*COL_W +: COL_W] = d_a[i*COL_W +: COL_W];
         end
      end
   end

   // Flag a same-address write-write overlap one cycle after it happens
   always_ff @(posedge clk) begin
      if (rst) begin
         coll <= 1'b0;
      end else begin
         coll <= en_a && en_b && (addr_a == addr_b) && (|(we_a & we_b));
      end
   end

   iob_ram_port_out #(
      .DATA_W  (DATA_W),
      .WR_MODE (WR_MODE),
      .OUT_REG (OUT_REG)
   ) u_out_a (
      .clk    (clk),
      .rst    (rst),
      .en     (en_a),
      .wr     (|we_a),
      .d_old  (old_a),
      .d_new  (new_a),
      .q      (q_a),
      .rvalid (rvalid_a)
   );

   iob_ram_port_out #(
      .DATA_W  (DATA_W),
      .WR_MODE (WR_MODE),
      .OUT_REG (OUT_REG)
   ) u_out_b (
      .clk    (clk),
      .rst    (rst),
      .en     (en_b),
      .wr     (|we_b),
      .d_old  (old_b),
      .d_new  (new_b),
      .q      (q_b),
      .rvalid (rvalid_b)
   );

endmodule
